// File: rtl/tdm_demux8.sv
// ============================================================================
// Module   : tdm_demux8
// Purpose  : Time-division demultiplexer. Splits one serial stream of eight
//            slot-interleaved channels back into eight parallel words. A
//            3-bit slot counter is locked to the frame-sync marker, and each
//            completed frame is presented on y with a one-cycle frame_valid.
// Ports    : clk         - single clock, rising edge
//            rst_n       - asynchronous active-low reset
//            en          - slot strobe; din/frame_sync sampled only when high
//            din         - current slot sample (W bits)
//            frame_sync  - marks the slot-0 sample
//            y           - reassembled frame, slot k at y[k*W +: W]
//            frame_valid - one-cycle pulse, y just updated
//            sync_err    - one-cycle pulse, framing error detected
//            locked      - high while locked to the frame marker
//            slot        - slot index the next en sample is written to
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tdm_demux8 #(
  parameter int W = 1
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           en,
  input  logic [W-1:0]   din,
  input  logic           frame_sync,
  output logic [8*W-1:0] y,
  output logic           frame_valid,
  output logic           sync_err,
  output logic           locked,
  output logic [2:0]     slot
);

  typedef enum logic {
    HUNT   = 1'b0,
    LOCKED = 1'b1
  } state_t;

  state_t         state_q, state_d;
  logic [2:0]     slot_q, slot_d;
  logic [W-1:0]   shadow_q [7];
  logic [W-1:0]   shadow_d [7];
  logic [8*W-1:0] y_q, y_d;
  logic           fv_q, fv_d;
  logic           err_q, err_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= HUNT;
      slot_q  <= 3'd0;
      y_q     <= '0;
      fv_q    <= 1'b0;
      err_q   <= 1'b0;
      for (int k = 0; k < 7; k++) begin
        shadow_q[k] <= '0;
      end
    end else begin
      state_q <= state_d;
      slot_q  <= slot_d;
      y_q     <= y_d;
      fv_q    <= fv_d;
      err_q   <= err_d;
      for (int k = 0; k < 7; k++) begin
        shadow_q[k] <= shadow_d[k];
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    slot_d   = slot_q;
    shadow_d = shadow_q;
    y_d      = y_q;
    fv_d     = 1'b0;
    err_d    = 1'b0;

    if (en) begin
      unique case (state_q)
        HUNT: begin
          if (frame_sync) begin
            shadow_d[0] = din;
            slot_d      = 3'd1;
            state_d     = LOCKED;
          end
        end

        LOCKED: begin
          if (slot_q == 3'd0) begin
            if (frame_sync) begin
              shadow_d[0] = din;
              slot_d      = 3'd1;
            end else begin
              // Marker missing where slot 0 should be: drop lock entirely.
              err_d   = 1'b1;
              state_d = HUNT;
            end
          end else if (frame_sync) begin
            // Early marker: abandon the partial frame and restart on it.
            err_d       = 1'b1;
            shadow_d[0] = din;
            slot_d      = 3'd1;
          end else if (slot_q == 3'd7) begin
            // Slot 7 bypasses the shadow store and lands directly in y.
            for (int k = 0; k < 7; k++) begin
              y_d[k*W +: W] = shadow_q[k];
            end
            y_d[7*W +: W] = din;
            fv_d          = 1'b1;
            slot_d        = 3'd0;
          end else begin
            for (int k = 1; k < 7; k++) begin
              if (slot_q == 3'(k)) begin
                shadow_d[k] = din;
              end
            end
            slot_d = slot_q + 3'd1;
          end
        end

        default: begin
          state_d = HUNT;
        end
      endcase
    end
  end

  assign y           = y_q;
  assign frame_valid = fv_q;
  assign sync_err    = err_q;
  assign locked      = (state_q == LOCKED);
  assign slot        = slot_q;

endmodule

`default_nettype wire

// File: tb/tb_tdm_demux8.sv
// ============================================================================
// Module   : tb_tdm_demux8
// Purpose  : Self-checking bench for tdm_demux8 (W=4). A fixed vector table,
//            hand-written corner sequences and a randomized run compared
//            against a queue-based frame model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_tdm_demux8;

  localparam int W = 4;

  logic           clk;
  logic           rst_n;
  logic           en;
  logic [W-1:0]   din;
  logic           frame_sync;
  logic [8*W-1:0] y;
  logic           frame_valid;
  logic           sync_err;
  logic           locked;
  logic [2:0]     slot;

  int total;
  int bad;

  tdm_demux8 #(.W(W)) u_dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .en          (en),
    .din         (din),
    .frame_sync  (frame_sync),
    .y           (y),
    .frame_valid (frame_valid),
    .sync_err    (sync_err),
    .locked      (locked),
    .slot        (slot)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: a frame is the queue of samples gathered since the
  // last accepted marker; lock is a flag, slot is simply the queue length.
  logic [W-1:0]   m_part [$];
  logic           m_locked;
  logic [8*W-1:0] m_y;
  logic           m_fv;
  logic           m_err;

  function automatic void model_reset();
    m_part.delete();
    m_locked = 1'b0;
    m_y      = '0;
    m_fv     = 1'b0;
    m_err    = 1'b0;
  endfunction

  function automatic void model_step(input logic e, input logic fs,
                                     input logic [W-1:0] d);
    m_fv  = 1'b0;
    m_err = 1'b0;
    if (!e) return;
    if (!m_locked) begin
      if (fs) begin
        m_locked = 1'b1;
        m_part.delete();
        m_part.push_back(d);
      end
    end else if (m_part.size() == 0) begin
      if (fs) m_part.push_back(d);
      else begin
        m_err    = 1'b1;
        m_locked = 1'b0;
      end
    end else if (fs) begin
      m_err = 1'b1;
      m_part.delete();
      m_part.push_back(d);
    end else begin
      m_part.push_back(d);
      if (m_part.size() == 8) begin
        for (int i = 0; i < 8; i++) m_y[i*W +: W] = m_part[i];
        m_fv = 1'b1;
        m_part.delete();
      end
    end
  endfunction

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_model(input string tag);
    check({tag, ".y"},      y,                 m_y);
    check({tag, ".fv"},     32'(frame_valid),  32'(m_fv));
    check({tag, ".err"},    32'(sync_err),     32'(m_err));
    check({tag, ".locked"}, 32'(locked),       32'(m_locked));
    check({tag, ".slot"},   32'(slot),         32'(m_part.size()));
  endtask

  // Drive inputs just after an edge, clock, then sample 1 time unit later.
  task automatic cyc(input logic e, input logic fs, input logic [W-1:0] d);
    en = e; frame_sync = fs; din = d;
    @(posedge clk);
    model_step(e, fs, d);
    #1;
  endtask

  task automatic do_reset();
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    check("rst.y",      y,                 32'h0);
    check("rst.fv",     32'(frame_valid),  32'h0);
    check("rst.err",    32'(sync_err),     32'h0);
    check("rst.locked", 32'(locked),       32'h0);
    check("rst.slot",   32'(slot),         32'h0);
    #1 rst_n = 1'b1;
  endtask

  typedef struct {
    logic           e;
    logic           fs;
    logic [W-1:0]   d;
    logic           fv;
    logic           err;
    logic           lk;
    logic [2:0]     sl;
    logic [8*W-1:0] yv;
  } vec_t;

  vec_t vt [$];

  function automatic void add(input logic e, input logic fs, input logic [W-1:0] d,
                              input logic fv, input logic err, input logic lk,
                              input logic [2:0] sl, input logic [8*W-1:0] yv);
    vec_t v;
    v.e = e; v.fs = fs; v.d = d; v.fv = fv; v.err = err; v.lk = lk; v.sl = sl; v.yv = yv;
    vt.push_back(v);
  endfunction

  initial begin
    int fv_cycles [$];
    int cnt;
    total = 0; bad = 0;
    rst_n = 1'b0; en = 1'b0; din = '0; frame_sync = 1'b0;
    model_reset();
    #12 rst_n = 1'b1;
    @(posedge clk); #1;
    check_model("init");

    // Frame 1,0,1,1,0,0,1,0 then idle with a stray marker on en=0
    add(1,1,1, 0,0,1,3'd1, 32'h0);
    add(1,0,0, 0,0,1,3'd2, 32'h0);
    add(1,0,1, 0,0,1,3'd3, 32'h0);
    add(1,0,1, 0,0,1,3'd4, 32'h0);
    add(1,0,0, 0,0,1,3'd5, 32'h0);
    add(1,0,0, 0,0,1,3'd6, 32'h0);
    add(1,0,1, 0,0,1,3'd7, 32'h0);
    add(1,0,0, 1,0,1,3'd0, 32'h01001101);
    add(0,1,5, 0,0,1,3'd0, 32'h01001101);
    // Early marker at slot 4, then a complete 8'hA5 frame
    add(1,1,1, 0,0,1,3'd1, 32'h01001101);
    add(1,0,0, 0,0,1,3'd2, 32'h01001101);
    add(1,0,1, 0,0,1,3'd3, 32'h01001101);
    add(1,0,1, 0,0,1,3'd4, 32'h01001101);
    add(1,1,1, 0,1,1,3'd1, 32'h01001101);
    add(1,0,0, 0,0,1,3'd2, 32'h01001101);
    add(1,0,1, 0,0,1,3'd3, 32'h01001101);
    add(1,0,0, 0,0,1,3'd4, 32'h01001101);
    add(1,0,0, 0,0,1,3'd5, 32'h01001101);
    add(1,0,1, 0,0,1,3'd6, 32'h01001101);
    add(1,0,0, 0,0,1,3'd7, 32'h01001101);
    add(1,0,1, 1,0,1,3'd0, 32'h10100101);
    // Missing marker, samples ignored while hunting, then relock
    add(1,0,3, 0,1,0,3'd0, 32'h10100101);
    add(1,0,1, 0,0,0,3'd0, 32'h10100101);
    add(1,0,1, 0,0,0,3'd0, 32'h10100101);
    add(1,1,2, 0,0,1,3'd1, 32'h10100101);

    foreach (vt[i]) begin
      cyc(vt[i].e, vt[i].fs, vt[i].d);
      check($sformatf("vec%0d.y", i),      y,                vt[i].yv);
      check($sformatf("vec%0d.fv", i),     32'(frame_valid), 32'(vt[i].fv));
      check($sformatf("vec%0d.err", i),    32'(sync_err),    32'(vt[i].err));
      check($sformatf("vec%0d.locked", i), 32'(locked),      32'(vt[i].lk));
      check($sformatf("vec%0d.slot", i),   32'(slot),        32'(vt[i].sl));
    end

    // Back-to-back frames, en held high: all-ones then all-zeros
    do_reset();
    cnt = 0;
    for (int f = 0; f < 2; f++) begin
      for (int k = 0; k < 8; k++) begin
        cyc(1'b1, k == 0, (f == 0) ? 4'hF : 4'h0);
        cnt++;
        check_model("b2b");
        if (frame_valid) fv_cycles.push_back(cnt);
        if (f == 0 && k == 7) check("b2b.y0", y, 32'hFFFFFFFF);
      end
    end
    check("b2b.y1", y, 32'h0);
    check("b2b.npulse", 32'(fv_cycles.size()), 32'd2);
    if (fv_cycles.size() == 2)
      check("b2b.spacing", 32'(fv_cycles[1] - fv_cycles[0]), 32'd8);

    // en toggling, marker pulsed only on en=0 cycles
    do_reset();
    begin
      logic [7:0] pat;
      pat = 8'h4D;
      for (int k = 0; k < 8; k++) begin
        cyc(1'b1, k == 0, {3'b0, pat[k]});
        check_model("tog");
        cyc(1'b0, 1'b1, 4'h7);
        check_model("tog0");
      end
    end
    check("tog.y", y, 32'h01001101);

    // Async reset mid-frame at slot 5, then a fresh frame of k+1 values
    for (int k = 0; k < 5; k++) cyc(1'b1, k == 0, 4'(k + 9));
    check("pre.slot", 32'(slot), 32'd5);
    do_reset();
    for (int k = 0; k < 8; k++) begin
      cyc(1'b1, k == 0, 4'(k + 1));
      check_model("post");
    end
    check("post.y", y, 32'h87654321);

    // Randomized run against the model
    for (int n = 0; n < 2000; n++) begin
      logic e, fs;
      e  = ($urandom_range(0, 3) != 0);
      fs = (m_part.size() == 0) ? ($urandom_range(0, 15) != 0)
                                : ($urandom_range(0, 31) == 0);
      cyc(e, fs, 4'($urandom));
      check_model("rnd");
      if (frame_valid && sync_err) check("rnd.excl", 32'h1, 32'h0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
